fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, byte address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 imem_req  output  1  instruction memory request valid.
REQ-005 imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
REQ-006 imem_ack  input  1  memory accepts the request and returns imem_rdata in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word, valid only when imem_ack=1.
REQ-008 redirect  input  1  downstream branch/jump taken; flush and restart fetch.
REQ-009 redirect_pc  input  32  restart address, sampled when redirect=1.
REQ-010 instr_valid  output  1  FIFO head holds a valid instruction for the decoder.
REQ-011 instr_ready  input  1  decoder consumes the head this cycle.
REQ-012 instr  output  32  head instruction; op=instr[31:26], funct=instr[5:0] feed the main/ALU decoders.
REQ-013 instr_pc  output  32  address of the head instruction.

Function
REQ-014 Internal state: fetch PC register, 2-entry instruction/PC FIFO, FSM {RUN, WAIT, DROP}.
REQ-015 At most one memory request outstanding at any time.
REQ-016 RUN: assert imem_req with imem_addr=PC when registered FIFO count<2; then next state WAIT unless imem_ack in the same cycle.
REQ-017 imem_req and imem_addr hold stable from assertion until the imem_ack cycle (inclusive).
REQ-018 On imem_ack in RUN/WAIT without redirect: push {imem_rdata, PC} into FIFO, PC<=PC+4 (mod 2^32, wrap 32'hFFFFFFFC->0), next state RUN.
REQ-019 Handshake: pop when instr_valid=1 and instr_ready=1; instr/instr_pc reflect head combinationally from registers.
REQ-020 Simultaneous push and pop with count=2 is legal only via pop-first; count stays 2; no overflow ever occurs because request is gated by count<2.
REQ-021 FIFO empty: instr_valid=0, instr and instr_pc hold last value (don't-care to decoder).
REQ-022 redirect=1 (highest priority): FIFO flushed same edge (count<=0), PC<=redirect_pc with bits [1:0] forced to 0; incoming ack data that cycle discarded.
REQ-023 redirect while in WAIT with no ack that cycle: next state DROP; request keeps old address until ack; acked data discarded; then RUN fetching from new PC.
REQ-024 redirect in DROP: PC updated again; state remains DROP.
REQ-025 Pop in the same cycle as redirect has no effect beyond the flush.
REQ-026 Latency: redirect edge to imem_req at new PC = 1 cycle (RUN) or ack+1 cycle (DROP); zero-wait memory ack to instr_valid = 1 cycle.

Reset
REQ-027 reset=0 asynchronously forces: PC=RESET_PC, FIFO count=0, state RUN, imem_req=0, instr_valid=0, instr=0, instr_pc=0.
REQ-028 Reset mid-transaction abandons any outstanding request; a late imem_ack after reset release while not requesting is ignored.
REQ-029 First imem_req asserts in the first cycle after reset deasserts.

Configuration
REQ-030 Macro FETCH_JUMP_PREDECODE_EN: when defined, an acked word with instr[31:26]=6'b000010 (j) is pushed normally but PC<={PC_plus4[31:28], instr[25:0], 2'b00} instead of PC+4.
REQ-031 Without FETCH_JUMP_PREDECODE_EN: j is treated as any instruction (PC+4); downstream redirect performs the jump.
REQ-032 External redirect overrides predecoded jump target in the same cycle.

Verification
REQ-033 Reset release, memory always acks, instr_ready=1 -> imem_addr 0,4,8,...; instr_pc matches; one instruction per cycle.
REQ-034 instr_ready=0 for 10 cycles -> exactly 2 instructions buffered, imem_req=0, no lost/duplicated words on resume.
REQ-035 Memory acks 3 cycles late, redirect to 32'h100 in WAIT -> old ack data dropped, next fetch at 32'h100, instr_pc=32'h100 first.
REQ-036 Redirect coincident with imem_ack and pop at count=2 -> FIFO empty next cycle, next imem_addr=redirect_pc.
REQ-037 With FETCH_JUMP_PREDECODE_EN, word 32'h08000040 at PC=0 -> next imem_addr=32'h100; without macro -> 32'h4.
REQ-038 reset pulsed low during WAIT -> outputs at reset values immediately; refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/ack, redirect, and decoder handshake.
// The master side belongs to fetch_unit; the slave side is memory plus the decode stage.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding request, 2-entry instr/PC FIFO, RUN/WAIT/DROP FSM.
// Optional FETCH_JUMP_PREDECODE_EN steers the PC straight to the target of an acked j.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {RUN, WAIT, DROP} state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, pc_plus4, req_addr;
  ent_t        fifo [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        ack, push, pop, flush;

  assign ack      = bus.imem_req && bus.imem_ack;
  assign flush    = bus.redirect;
  assign push     = ack && (state != DROP) && !flush;
  assign pop      = bus.instr_valid && bus.instr_ready && !flush;
  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.imem_req && !bus.imem_ack) state_nxt = flush ? DROP : WAIT;
      WAIT:    if (bus.imem_ack) state_nxt = RUN;
               else if (flush)   state_nxt = DROP;
      DROP:    if (bus.imem_ack) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Request is gated by reset so it drops asynchronously; once issued the
  // address comes from req_addr so a redirect cannot disturb it.
  always_comb begin
    bus.imem_req  = 1'b0;
    bus.imem_addr = pc;
    case (state)
      RUN:       bus.imem_req = reset && (count != 2'd2);
      WAIT, DROP: begin
        bus.imem_req  = reset;
        bus.imem_addr = req_addr;
      end
      default:   bus.imem_req = 1'b0;
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    if (flush) begin
      pc_nxt = {bus.redirect_pc[31:2], 2'b00};
    end else if (push) begin
`ifdef FETCH_JUMP_PREDECODE_EN
      if (bus.imem_rdata[31:26] == 6'b000010)
        pc_nxt = {pc_plus4[31:28], bus.imem_rdata[25:0], 2'b00};
      else
        pc_nxt = pc_plus4;
`else
      pc_nxt = pc_plus4;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo[0]  <= '0;
      fifo[1]  <= '0;
    end else begin
      pc <= pc_nxt;
      if (state == RUN && bus.imem_req) req_addr <= pc;
      if (push) begin
        fifo[wr_ptr] <= '{instr: bus.imem_rdata, pc: bus.imem_addr};
        wr_ptr       <= ~wr_ptr;
      end
      if (flush) begin
        count  <= 2'd0;
        rd_ptr <= wr_ptr;
      end else begin
        count  <= count + {1'b0, push} - {1'b0, pop};
        if (pop) rd_ptr <= ~rd_ptr;
      end
    end
  end

  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr       = fifo[rd_ptr].instr;
  assign bus.instr_pc    = fifo[rd_ptr].pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with programmable ack latency, hand-computed expectations.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();
  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .reset(reset), .bus(bus));

  int unsigned lat  = 0;
  int unsigned wcnt = 0;
  logic        jmp  = 1'b0;
  int tests = 0;
  int fails = 0;

  // Memory: data = C000_0000 | address, except a j word at address 0 when jmp is set.
  assign bus.imem_ack   = bus.imem_req && (wcnt >= lat);
  assign bus.imem_rdata = (jmp && bus.imem_addr == 32'h0) ? 32'h0800_0040 : (32'hC000_0000 | bus.imem_addr);
  always @(posedge clk) begin
    if (!bus.imem_req || bus.imem_ack) wcnt <= 0;
    else                               wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b1;
    #1;
    chk1("rst_req",   bus.imem_req, 1'b0);
    chk1("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_instr",  bus.instr, 32'h0);
    chk("rst_pc",     bus.instr_pc, 32'h0);

    // Release reset mid-cycle: request must appear immediately at RESET_PC.
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    chk1("first_req", bus.imem_req, 1'b1);
    chk("first_addr", bus.imem_addr, 32'h0);
    tick();
    chk1("s0_valid", bus.instr_valid, 1'b1);
    chk("s0_pc",     bus.instr_pc, 32'h0);
    chk("s0_instr",  bus.instr, 32'hC000_0000);
    chk("s0_addr",   bus.imem_addr, 32'h4);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("stream_pc",   bus.instr_pc, 32'(4 * k));
      chk("stream_addr", bus.imem_addr, 32'(4 * k + 4));
    end

    // Decoder stalls for 10 cycles: FIFO fills to 2 and requests stop.
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk1("stall_req", bus.imem_req, 1'b0);
    end
    chk1("stall_valid", bus.instr_valid, 1'b1);
    chk("stall_pc",     bus.instr_pc, 32'hC);
    chk("stall_instr",  bus.instr, 32'hC000_000C);
    bus.instr_ready = 1'b1;
    tick();
    chk("resume_pc0",  bus.instr_pc, 32'h10);
    chk("resume_addr", bus.imem_addr, 32'h14);
    tick();
    chk("resume_pc1",  bus.instr_pc, 32'h14);
    chk("resume_addr1", bus.imem_addr, 32'h18);

    // Slow memory, redirect while waiting: old data dropped, refetch at 0x100.
    lat = 3;
    tick();
    chk1("wait_valid", bus.instr_valid, 1'b0);
    chk("wait_addr",   bus.imem_addr, 32'h18);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    #1;
    chk("wait_hold", bus.imem_addr, 32'h18);
    tick();
    bus.redirect = 1'b0;
    chk1("drop_req", bus.imem_req, 1'b1);
    chk("drop_addr", bus.imem_addr, 32'h18);
    tick();
    chk("drop_ack_addr", bus.imem_addr, 32'h18);
    tick();
    chk1("drop_valid", bus.instr_valid, 1'b0);
    chk("new_addr",    bus.imem_addr, 32'h100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("newwait_valid", bus.instr_valid, 1'b0);
    end
    tick();
    chk1("new_valid", bus.instr_valid, 1'b1);
    chk("new_pc",     bus.instr_pc, 32'h100);
    chk("new_instr",  bus.instr, 32'hC000_0100);
    lat = 0;

    // Redirect coincident with ack and pop: flushed, low address bits cleared.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h203;
    tick();
    bus.redirect = 1'b0;
    chk1("rd1_valid", bus.instr_valid, 1'b0);
    chk1("rd1_req",   bus.imem_req, 1'b1);
    chk("rd1_addr",   bus.imem_addr, 32'h200);
    tick();
    chk("rd1_pc", bus.instr_pc, 32'h200);

    // Fill to 2, then redirect with a pop at count 2.
    bus.instr_ready = 1'b0;
    tick();
    chk1("full_req", bus.imem_req, 1'b0);
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    tick();
    bus.redirect = 1'b0;
    chk1("rd2_valid", bus.instr_valid, 1'b0);
    chk("rd2_addr",   bus.imem_addr, 32'h300);
    tick();
    chk1("rd2_valid1", bus.instr_valid, 1'b1);
    chk("rd2_pc",      bus.instr_pc, 32'h300);

    // j at address 0.
    jmp             = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0;
    tick();
    bus.redirect = 1'b0;
    chk("j_fetch_addr", bus.imem_addr, 32'h0);
    tick();
    chk("j_instr", bus.instr, 32'h0800_0040);
    chk("j_pc",    bus.instr_pc, 32'h0);
`ifdef FETCH_JUMP_PREDECODE_EN
    chk("j_next_addr", bus.imem_addr, 32'h100);
`else
    chk("j_next_addr", bus.imem_addr, 32'h4);
`endif
    jmp = 1'b0;

    // Reset pulse during WAIT.
    lat = 3;
    tick();
    chk1("w2_req", bus.imem_req, 1'b1);
    reset = 1'b0;
    #1;
    chk1("mid_rst_req",   bus.imem_req, 1'b0);
    chk1("mid_rst_valid", bus.instr_valid, 1'b0);
    chk("mid_rst_instr",  bus.instr, 32'h0);
    chk("mid_rst_pc",     bus.instr_pc, 32'h0);
    tick();
    reset = 1'b1;
    lat   = 0;
    #1;
    chk1("refetch_req", bus.imem_req, 1'b1);
    chk("refetch_addr", bus.imem_addr, 32'h0);
    tick();
    chk1("refetch_valid", bus.instr_valid, 1'b1);
    chk("refetch_pc",     bus.instr_pc, 32'h0);
    chk("refetch_instr",  bus.instr, 32'hC000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
